pp_pipeline_accel_hls_deadlock_report_unit: RTL and testbench
=============================================================

Name: pp_pipeline_accel_hls_deadlock_report_unit

Overview:
- Central collector downstream of the per-process deadlock detect units.
- On the first dl_detect_out from any unit, it:
  - latches the detecting process;
  - broadcasts the detected condition to all units;
  - pulses origin to that process;
  - follows the report token around the dependence cycle.
- Records the process IDs visited in a trace FIFO for host readout.
- Issues token_clear when the token returns to the origin.

Parameters:
- PROC_NUM, 4, number of dataflow processes (detect units).
- ID_W, 2, process ID width; 2**ID_W >= PROC_NUM.
- TRACE_DEPTH, 8, trace FIFO entries; power of two, >= 2.
- WALK_TIMEOUT, 1024, max idle cycles in WALK with no token seen.
- CNT_W, 32, cycle counter width (optional feature only).

Ports:
- reset  in  1  asynchronous, active-low.
- clock  in  1  rising-edge clock.
- dl_in_vec  in  PROC_NUM  bit i = dl_detect_out of detect unit i.
- token_vec  in  PROC_NUM  bit i = OR of token_in_vec at unit i.
- sw_clear  in  1  synchronous clear of report; returns FSM to IDLE.
- dl_detect_bcast  out  1  dl_detect_in driven to every detect unit.
- origin_vec  out  PROC_NUM  one-hot origin pulse, indexed by process.
- token_clear  out  1  token_clear driven to every detect unit.
- deadlock  out  1  sticky deadlock-detected flag.
- walk_done  out  1  trace complete (token returned or timeout).
- walk_timeout  out  1  sticky; walk ended by timeout.
- trace_overflow  out  1  sticky; push attempted while FIFO full.
- trace_empty  out  1  FIFO empty.
- trace_count  out  $clog2(TRACE_DEPTH)+1  FIFO occupancy.
- trace_rd_en  in  1  pop head entry.
- trace_rd_data  out  ID_W  head entry; first-word-fall-through.
- cycles_to_detect  out  CNT_W  present only with the optional feature.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, except trace_empty = 1.
  - FIFO pointers, occupancy, origin_id, timeout counter all 0.
- States: IDLE, ORIGIN, WALK, DONE. dl_detect_bcast = (state != IDLE), registered from next-state.
- IDLE:
  - If |dl_in_vec, latch origin_id = lowest set index and set deadlock.
  - Next state ORIGIN.
- ORIGIN (exactly 1 cycle):
  - origin_vec = 1 << origin_id.
  - Push origin_id into the FIFO.
  - Next state WALK; timeout counter cleared.
- WALK:
  - token_clear is combinational: (state==WALK) & token_vec[origin_id]. It is asserted in the same cycle the token reaches the origin.
  - Then: walk_done = 1, next state DONE, nothing pushed.
  - Otherwise, if |token_vec: push the lowest set index and reset the timeout counter.
  - Otherwise the timeout counter increments. At WALK_TIMEOUT-1: set walk_timeout and walk_done, next state DONE.
  - dl_in_vec is ignored outside IDLE.
- DONE: hold all flags; FIFO remains readable.
- sw_clear:
  - Takes effect in any state, with priority over all transitions.
  - Next cycle: state IDLE; deadlock, walk_done, walk_timeout, trace_overflow cleared; FIFO flushed; origin_vec and token_clear forced 0 that cycle.
- FIFO rules:
  - Push when full: data dropped, trace_overflow set, occupancy unchanged.
  - Pop when empty: ignored.
  - Simultaneous push and pop when full: both succeed, occupancy unchanged, no overflow.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo TRACE_DEPTH.
- Async reset mid-walk aborts everything. origin_vec and token_clear are never asserted during reset.

Optional Feature:
- Macro: PP_DL_REPORT_CYCLE_CNT_EN.
- With the macro:
  - A CNT_W counter counts clock cycles from reset deassertion (or from sw_clear) while in IDLE.
  - On the IDLE->ORIGIN transition its value is latched into cycles_to_detect.
  - The counter saturates at all-ones.
  - sw_clear zeroes both the counter and cycles_to_detect.
- Without the macro: cycles_to_detect port, counter and latch are absent; all other behaviour is identical.

Test Plan:
- No deadlock:
  - Stimulus: dl_in_vec=0 for 500 cycles, random token_vec.
  - Required: deadlock=0, dl_detect_bcast=0, origin_vec=0, trace_empty=1.
- Cycle 1->3->0->1:
  - Stimulus: dl_in_vec=4'b0010 at cycle 10; token_vec bits 3, 0, 1 on successive cycles after ORIGIN.
  - Required: origin_vec=4'b0010 for 1 cycle; token_clear high in the bit-1 cycle; FIFO pops 1,3,0; walk_done=1.
- Simultaneous detect:
  - Stimulus: dl_in_vec=4'b1100.
  - Required: origin_id=2, origin_vec=4'b0100.
- Overflow:
  - Stimulus: TRACE_DEPTH=8; walk of 10 non-origin hops; no reads.
  - Required: trace_count=8, trace_overflow=1.
  - Then: concurrent pop+push at full gives count 8 and no new overflow.
- Timeout:
  - Stimulus: token_vec=0 after ORIGIN.
  - Required: walk_timeout=1 and walk_done=1 exactly WALK_TIMEOUT cycles after entering WALK; token_clear never asserted.
- Clear / reset mid-walk, plus optional feature:
  - Stimulus: sw_clear mid-WALK.
  - Required: IDLE next cycle, all flags 0, trace_empty=1.
  - Stimulus: async reset pulse mid-WALK.
  - Required: same result immediately.
  - With macro, detect at cycle 37 after clear: cycles_to_detect=37.

Source files
------------

// File: rtl/pp_pipeline_accel_hls_deadlock_report_unit_if.sv
// Detect-unit side bus of the deadlock report unit: detect/token inputs, broadcast/origin/clear outputs.
// master = report unit, slave = the bank of per-process detect units.
interface pp_pipeline_accel_hls_deadlock_report_unit_if #(
   parameter int PROC_NUM = 4
) ();
   logic [PROC_NUM-1:0] dl_in_vec;
   logic [PROC_NUM-1:0] token_vec;
   logic                dl_detect_bcast;
   logic [PROC_NUM-1:0] origin_vec;
   logic                token_clear;

   modport master (
      input  dl_in_vec, token_vec,
      output dl_detect_bcast, origin_vec, token_clear
   );

   modport slave (
      output dl_in_vec, token_vec,
      input  dl_detect_bcast, origin_vec, token_clear
   );
endinterface

// File: rtl/pp_pipeline_accel_hls_deadlock_report_unit.sv
// Deadlock report collector: latches first detector, walks the report token, traces IDs into a FWFT FIFO.
// origin_vec/token_clear combinational from state; no backpressure. PP_DL_REPORT_CYCLE_CNT_EN adds cycles_to_detect.
module pp_pipeline_accel_hls_deadlock_report_unit #(
   parameter int PROC_NUM     = 4,
   parameter int ID_W         = 2,
   parameter int TRACE_DEPTH  = 8,
   parameter int WALK_TIMEOUT = 1024,
   parameter int CNT_W        = 32
) (
   input  logic                              clock,
   input  logic                              reset,
   pp_pipeline_accel_hls_deadlock_report_unit_if.master du,
   input  logic                              sw_clear,
   output logic                              deadlock,
   output logic                              walk_done,
   output logic                              walk_timeout,
   output logic                              trace_overflow,
   output logic                              trace_empty,
   output logic [$clog2(TRACE_DEPTH):0]      trace_count,
   input  logic                              trace_rd_en,
   output logic [ID_W-1:0]                   trace_rd_data
`ifdef PP_DL_REPORT_CYCLE_CNT_EN
   ,
   output logic [CNT_W-1:0]                  cycles_to_detect
`endif
);
   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam int TO_W  = $clog2(WALK_TIMEOUT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ORIGIN, S_WALK, S_DONE} state_t;

   state_t          state;
   logic [ID_W-1:0] origin_id;
   logic [TO_W-1:0] to_cnt;
   logic            bcast_q;

   logic            push_req;
   logic [ID_W-1:0] push_id;
   logic            tok_at_origin;

   logic [ID_W-1:0]  mem [TRACE_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [ID_W-1:0] lowest(input logic [PROC_NUM-1:0] v);
      lowest = '0;
      for (int i = PROC_NUM - 1; i >= 0; i--)
         if (v[i]) lowest = ID_W'(i);
   endfunction

   assign tok_at_origin = du.token_vec[origin_id];

   always_comb begin
      push_req = 1'b0;
      push_id  = origin_id;
      if (!sw_clear) begin
         if (state == S_ORIGIN) begin
            push_req = 1'b1;
         end else if (state == S_WALK && !tok_at_origin && (|du.token_vec)) begin
            push_req = 1'b1;
            push_id  = lowest(du.token_vec);
         end
      end
   end

   // sw_clear masks the pulses in the very cycle it is raised
   assign du.token_clear     = (state == S_WALK) && tok_at_origin && !sw_clear;
   assign du.origin_vec      = (state == S_ORIGIN && !sw_clear)
                               ? ({{(PROC_NUM-1){1'b0}}, 1'b1} << origin_id) : '0;
   assign du.dl_detect_bcast = bcast_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         origin_id    <= '0;
         to_cnt       <= '0;
         bcast_q      <= 1'b0;
         deadlock     <= 1'b0;
         walk_done    <= 1'b0;
         walk_timeout <= 1'b0;
      end else if (sw_clear) begin
         state        <= S_IDLE;
         to_cnt       <= '0;
         bcast_q      <= 1'b0;
         deadlock     <= 1'b0;
         walk_done    <= 1'b0;
         walk_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|du.dl_in_vec) begin
                  origin_id <= lowest(du.dl_in_vec);
                  deadlock  <= 1'b1;
                  bcast_q   <= 1'b1;
                  state     <= S_ORIGIN;
               end
            end
            S_ORIGIN: begin
               to_cnt <= '0;
               state  <= S_WALK;
            end
            S_WALK: begin
               if (tok_at_origin) begin
                  walk_done <= 1'b1;
                  state     <= S_DONE;
               end else if (|du.token_vec) begin
                  to_cnt <= '0;
               end else if (to_cnt == TO_W'(WALK_TIMEOUT - 1)) begin
                  walk_timeout <= 1'b1;
                  walk_done    <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            default: state <= S_DONE;
         endcase
      end
   end

   // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it
   assign full        = (trace_count == CW'(TRACE_DEPTH));
   assign do_pop      = trace_rd_en && (trace_count != '0);
   assign do_push     = push_req && (!full || do_pop);
   assign trace_empty = (trace_count == '0);
   assign trace_rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push && !sw_clear) mem[wr_ptr] <= push_id;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         trace_count    <= '0;
         trace_overflow <= 1'b0;
      end else if (sw_clear) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         trace_count    <= '0;
         trace_overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_req && !do_push) trace_overflow <= 1'b1;
         if (do_push && !do_pop)
            trace_count <= trace_count + CW'(1);
         else if (!do_push && do_pop)
            trace_count <= trace_count - CW'(1);
      end
   end

`ifdef PP_DL_REPORT_CYCLE_CNT_EN
   logic [CNT_W-1:0] cyc_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cyc_cnt          <= '0;
         cycles_to_detect <= '0;
      end else if (sw_clear) begin
         cyc_cnt          <= '0;
         cycles_to_detect <= '0;
      end else if (state == S_IDLE) begin
         if (|du.dl_in_vec) cycles_to_detect <= cyc_cnt;
         if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_pp_pipeline_accel_hls_deadlock_report_unit.sv
// Directed vector bench for the deadlock report unit: per-cycle table plus overflow, clear, reset and timeout sequences.
module tb_pp_pipeline_accel_hls_deadlock_report_unit;
   localparam int PROC_NUM     = 4;
   localparam int ID_W         = 2;
   localparam int TRACE_DEPTH  = 8;
   localparam int WALK_TIMEOUT = 1024;
   localparam int CNT_W        = 32;
   localparam int CW           = $clog2(TRACE_DEPTH) + 1;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            sw_clear = 1'b0;
   logic            trace_rd_en = 1'b0;
   logic            deadlock, walk_done, walk_timeout, trace_overflow, trace_empty;
   logic [CW-1:0]   trace_count;
   logic [ID_W-1:0] trace_rd_data;
`ifdef PP_DL_REPORT_CYCLE_CNT_EN
   logic [CNT_W-1:0] cycles_to_detect;
`endif

   pp_pipeline_accel_hls_deadlock_report_unit_if #(.PROC_NUM(PROC_NUM)) du ();

   pp_pipeline_accel_hls_deadlock_report_unit #(
      .PROC_NUM(PROC_NUM), .ID_W(ID_W), .TRACE_DEPTH(TRACE_DEPTH),
      .WALK_TIMEOUT(WALK_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .du(du), .sw_clear(sw_clear),
      .deadlock(deadlock), .walk_done(walk_done), .walk_timeout(walk_timeout),
      .trace_overflow(trace_overflow), .trace_empty(trace_empty),
      .trace_count(trace_count), .trace_rd_en(trace_rd_en), .trace_rd_data(trace_rd_data)
`ifdef PP_DL_REPORT_CYCLE_CNT_EN
      , .cycles_to_detect(cycles_to_detect)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] dl, tok;
      logic       clr, rd;
      logic       bcast;
      logic [3:0] org;
      logic       tclr, dead, done, tmo, ovf, empty;
      logic [3:0] cnt;
      logic       rchk;
      logic [1:0] rdat;
   } vec_t;

   vec_t tv[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   function automatic vec_t mk(input logic [3:0] dl, tok, input logic clr, rd, bcast,
                               input logic [3:0] org, input logic tclr, dead, done, tmo, ovf, empty,
                               input logic [3:0] cnt, input logic rchk, input logic [1:0] rdat);
      vec_t v;
      v.dl = dl; v.tok = tok; v.clr = clr; v.rd = rd; v.bcast = bcast; v.org = org;
      v.tclr = tclr; v.dead = dead; v.done = done; v.tmo = tmo; v.ovf = ovf;
      v.empty = empty; v.cnt = cnt; v.rchk = rchk; v.rdat = rdat;
      return v;
   endfunction

   initial begin
      logic [1:0] q[$];
      logic       saw_tclr;
      int         id;

      du.dl_in_vec = '0;
      du.token_vec = '0;

      //          dl    tok  clr rd bc org  tc dd dn to ov em cnt rc rd
      tv.push_back(mk(4'h0,4'h0,0,0, 0,4'h0,0,0,0,0,0,1,4'd0,0,2'd0)); // idle
      tv.push_back(mk(4'h2,4'h0,0,0, 0,4'h0,0,0,0,0,0,1,4'd0,0,2'd0)); // detect unit 1
      tv.push_back(mk(4'h0,4'h0,0,0, 1,4'h2,0,1,0,0,0,1,4'd0,0,2'd0)); // ORIGIN
      tv.push_back(mk(4'h1,4'h8,0,0, 1,4'h0,0,1,0,0,0,0,4'd1,1,2'd1)); // hop 3, dl ignored
      tv.push_back(mk(4'h0,4'h1,0,0, 1,4'h0,0,1,0,0,0,0,4'd2,1,2'd1)); // hop 0
      tv.push_back(mk(4'h0,4'h2,0,0, 1,4'h0,1,1,0,0,0,0,4'd3,1,2'd1)); // back at origin
      tv.push_back(mk(4'h0,4'h2,0,0, 1,4'h0,0,1,1,0,0,0,4'd3,1,2'd1)); // DONE ignores token
      tv.push_back(mk(4'h0,4'h0,0,1, 1,4'h0,0,1,1,0,0,0,4'd3,1,2'd1));
      tv.push_back(mk(4'h0,4'h0,0,1, 1,4'h0,0,1,1,0,0,0,4'd2,1,2'd3));
      tv.push_back(mk(4'h0,4'h0,0,1, 1,4'h0,0,1,1,0,0,0,4'd1,1,2'd0));
      tv.push_back(mk(4'h0,4'h0,0,1, 1,4'h0,0,1,1,0,0,1,4'd0,0,2'd0)); // pop when empty
      tv.push_back(mk(4'h0,4'h0,0,0, 1,4'h0,0,1,1,0,0,1,4'd0,0,2'd0));
      tv.push_back(mk(4'h0,4'h2,1,0, 1,4'h0,0,1,1,0,0,1,4'd0,0,2'd0)); // sw_clear in DONE
      tv.push_back(mk(4'h0,4'h0,0,0, 0,4'h0,0,0,0,0,0,1,4'd0,0,2'd0));
      tv.push_back(mk(4'hC,4'h0,0,0, 0,4'h0,0,0,0,0,0,1,4'd0,0,2'd0)); // simultaneous 2,3
      tv.push_back(mk(4'hC,4'h0,0,0, 1,4'h4,0,1,0,0,0,1,4'd0,0,2'd0));
      tv.push_back(mk(4'h0,4'h4,0,0, 1,4'h0,1,1,0,0,0,0,4'd1,1,2'd2)); // immediate return
      tv.push_back(mk(4'h0,4'h0,0,0, 1,4'h0,0,1,1,0,0,0,4'd1,1,2'd2));
      tv.push_back(mk(4'h0,4'h0,1,0, 1,4'h0,0,1,1,0,0,0,4'd1,1,2'd2));
      tv.push_back(mk(4'h1,4'h0,0,0, 0,4'h0,0,0,0,0,0,1,4'd0,0,2'd0));
      tv.push_back(mk(4'h0,4'h0,1,0, 1,4'h0,0,1,0,0,0,1,4'd0,0,2'd0)); // clear masks origin
      tv.push_back(mk(4'h0,4'h0,0,0, 0,4'h0,0,0,0,0,0,1,4'd0,0,2'd0));

      #3;
      chk("rst_deadlock", deadlock, 0);
      chk("rst_bcast", du.dl_detect_bcast, 0);
      chk("rst_origin", du.origin_vec, 0);
      chk("rst_tclr", du.token_clear, 0);
      chk("rst_flags", {walk_done, walk_timeout, trace_overflow}, 0);
      chk("rst_empty", trace_empty, 1);
      chk("rst_count", trace_count, 0);
      #9 reset = 1'b1;
      cyc();

      for (int i = 0; i < 500; i++) begin
         du.token_vec = 4'($urandom_range(0, 15));
         trace_rd_en  = 1'($urandom_range(0, 1));
         #1;
         chk("quiet", {deadlock, du.dl_detect_bcast, du.origin_vec, du.token_clear, trace_empty}, 8'h01);
         cyc();
      end
      du.token_vec = '0;
      trace_rd_en  = 1'b0;

      foreach (tv[i]) begin
         du.dl_in_vec = tv[i].dl;
         du.token_vec = tv[i].tok;
         sw_clear     = tv[i].clr;
         trace_rd_en  = tv[i].rd;
         #1;
         chk($sformatf("v%0d_bcast", i), du.dl_detect_bcast, tv[i].bcast);
         chk($sformatf("v%0d_origin", i), du.origin_vec, tv[i].org);
         chk($sformatf("v%0d_tclr", i), du.token_clear, tv[i].tclr);
         chk($sformatf("v%0d_flags", i), {deadlock, walk_done, walk_timeout, trace_overflow},
             {tv[i].dead, tv[i].done, tv[i].tmo, tv[i].ovf});
         chk($sformatf("v%0d_empty", i), trace_empty, tv[i].empty);
         chk($sformatf("v%0d_count", i), trace_count, tv[i].cnt);
         if (tv[i].rchk) chk($sformatf("v%0d_rdata", i), trace_rd_data, tv[i].rdat);
         cyc();
      end
      du.dl_in_vec = '0; du.token_vec = '0; sw_clear = 1'b0; trace_rd_en = 1'b0;

      // Overflow: origin 0, eleven non-origin hops, one concurrent pop+push at full
      du.dl_in_vec = 4'h1; cyc();
      du.dl_in_vec = 4'h0; cyc();
      q = {2'd0};
      for (int k = 1; k <= 11; k++) begin
         id = (k - 1) % 3 + 1;
         du.token_vec = 4'(1 << id);
         trace_rd_en  = (k == 8);
         #1;
         if (k == 8 || k == 9) begin
            chk($sformatf("ovf_pre%0d_count", k), trace_count, 8);
            chk($sformatf("ovf_pre%0d_flag", k), trace_overflow, 0);
         end
         cyc();
         if (trace_rd_en && q.size() != 0) void'(q.pop_front());
         if (q.size() < TRACE_DEPTH) q.push_back(2'(id));
      end
      du.token_vec = '0;
      trace_rd_en  = 1'b0;
      #1;
      chk("ovf_count", trace_count, 8);
      chk("ovf_flag", trace_overflow, 1);
      cyc();
      trace_rd_en = 1'b1;
      for (int k = 0; k < TRACE_DEPTH; k++) begin
         #1;
         chk($sformatf("ovf_pop%0d", k), trace_rd_data, q.pop_front());
         cyc();
      end
      trace_rd_en = 1'b0;
      #1;
      chk("ovf_drained", {trace_empty, trace_count}, {1'b1, 4'd0});

      // sw_clear mid-walk with the token at the origin
      du.token_vec = 4'h1;
      sw_clear     = 1'b1;
      #1;
      chk("clr_tclr_masked", du.token_clear, 0);
      cyc();
      du.token_vec = '0;
      sw_clear     = 1'b0;
      #1;
      chk("clr_flags", {deadlock, walk_done, walk_timeout, trace_overflow, du.dl_detect_bcast}, 0);
      chk("clr_empty", {trace_empty, trace_count}, {1'b1, 4'd0});
      cyc();

      // Asynchronous reset in the middle of a walk
      du.dl_in_vec = 4'h1; cyc();
      du.dl_in_vec = 4'h0; cyc();
      du.token_vec = 4'h4; cyc();
      du.token_vec = 4'h1;
      #1;
      chk("ar_tclr_before", du.token_clear, 1);
      chk("ar_count_before", trace_count, 2);
      reset = 1'b0;
      #1;
      chk("ar_tclr", du.token_clear, 0);
      chk("ar_flags", {deadlock, walk_done, du.dl_detect_bcast, du.origin_vec}, 0);
      chk("ar_empty", {trace_empty, trace_count}, {1'b1, 4'd0});
      #3 reset = 1'b1;
      du.token_vec = '0;
      cyc();
      #1;
      chk("ar_idle", {deadlock, du.dl_detect_bcast}, 0);
      cyc();

      // Timeout: no token after ORIGIN
      du.dl_in_vec = 4'h1; cyc();
      du.dl_in_vec = 4'h0; cyc();
      saw_tclr = 1'b0;
      for (int k = 1; k < WALK_TIMEOUT; k++) begin
         cyc();
         saw_tclr = saw_tclr | du.token_clear;
      end
      #1;
      chk("to_early", {walk_done, walk_timeout}, 0);
      cyc();
      saw_tclr = saw_tclr | du.token_clear;
      #1;
      chk("to_fired", {walk_done, walk_timeout}, 2'b11);
      chk("to_no_tclr", saw_tclr, 0);
      chk("to_count", trace_count, 1);

`ifdef PP_DL_REPORT_CYCLE_CNT_EN
      sw_clear = 1'b1; cyc();
      sw_clear = 1'b0;
      repeat (37) cyc();
      du.dl_in_vec = 4'h2; cyc();
      du.dl_in_vec = 4'h0;
      #1;
      chk("cycles_to_detect", cycles_to_detect, 37);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
